rv_if_stage: RTL
================

Name: rv_if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the rv32i 5-stage pipeline.
- Holds the fetch PC and drives the instruction memory address. Captures the fetched word into the IF/ID register.
- Holds on the hazard unit's IF/ID stall. Flushes and redirects on a taken branch or jump resolved in EX.
- Sits directly upstream of the decode stage; its stall input is the hazard unit's IF/ID stall output.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven into ID on flush or reset.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_if_stall  input  1  hold PC and IF/ID register (from hazard unit stall for IF/ID).
- i_if_redirect  input  1  taken branch or jump from EX; flush IF/ID and load new PC.
- i_if_redirect_pc  input  32  branch or jump target from EX.
- o_if_imem_addr  output  32  instruction memory address (combinational read memory).
- i_if_imem_rdata  input  32  instruction word at o_if_imem_addr, same cycle.
- o_if_pc_id  output  32  PC of the instruction in ID.
- o_if_pc4_id  output  32  o_if_pc_id + 4, registered.
- o_if_instr_id  output  32  instruction in ID.
- o_if_valid_id  output  1  ID holds a real (non-bubble) instruction.
- o_if_flush_cnt  output  16  saturating count of redirect flushes since reset.

Behaviour:
- Clock and reset: one clock i_clk. Reset i_rst is synchronous and active-high.
- Reset values:
  - pc_f = RESET_PC
  - o_if_pc_id = 0
  - o_if_pc4_id = 0
  - o_if_instr_id = NOP_INSTR
  - o_if_valid_id = 0
  - o_if_flush_cnt = 0
- Reset has priority over every other input. Reset asserted mid-stall or mid-redirect discards all in-flight state.
- o_if_imem_addr = pc_f, combinational. The fetch PC register pc_f is internal.
- Next-PC priority, evaluated each cycle:
  1. i_if_redirect = 1: pc_f <= {i_if_redirect_pc[31:2], 2'b00}. Bits [1:0] are cleared in hardware.
  2. Else i_if_stall = 1: pc_f holds.
  3. Else pc_f <= pc_f + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- IF/ID register, using the same priority:
  - Redirect (flush), regardless of stall:
    - o_if_instr_id <= NOP_INSTR
    - o_if_valid_id <= 0
    - o_if_pc_id <= pc_f, o_if_pc4_id <= pc_f + 4 (PC fields are don't-care for verification while valid = 0)
  - Stall (no redirect): all IF/ID fields hold, bit-exact.
  - Advance:
    - o_if_pc_id <= pc_f
    - o_if_pc4_id <= pc_f + 4 (wraps)
    - o_if_instr_id <= i_if_imem_rdata
    - o_if_valid_id <= 1
- Latency: the word at address A appears on o_if_instr_id one cycle after pc_f = A, provided that cycle is not stalled or flushed.
- First cycle after reset release: o_if_valid_id = 0 and imem_addr = RESET_PC. Next cycle: valid = 1 with the RESET_PC instruction.
- Redirect penalty: with redirect at cycle n (target T):
  - cycle n+1: ID holds a bubble and pc_f = T.
  - cycle n+2: ID holds instr(T), valid = 1.
- Simultaneous redirect and stall: redirect wins. The stall is ignored for both PC and IF/ID.
- Back-to-back redirects: each one reloads pc_f and flushes. Only the last target is fetched.
- Stall held for N cycles: pc_f and the IF/ID fields are frozen N cycles. i_if_imem_rdata is ignored while stalled.
- o_if_flush_cnt increments by 1 on each cycle with i_if_redirect = 1 and i_rst = 0. It saturates at 16'hFFFF and does not wrap.
- No X-propagation from i_if_imem_rdata into o_if_instr_id while flushed or in reset.
- The block holds no state machine beyond the registers listed. The module must not use latches.

Test Plan:
- Reset then release, imem returns word = address: cycle 1 gives valid = 0 and imem_addr = 0. Cycle 2 gives pc_id = 0, instr = 0, valid = 1. Cycle 3 gives pc_id = 4, pc4_id = 8.
- Stall for 3 cycles while pc_f = 0x10: imem_addr stays 0x10, pc_id stays 0xC and instr stays 0xC for 3 cycles. On release, ID shows 0x10.
- Redirect to 0x100 while pc_f = 0x20:
  - next cycle: instr = 0x0000_0013, valid = 0, imem_addr = 0x100, flush_cnt = 1.
  - cycle after: pc_id = 0x100, valid = 1.
- Redirect to 0x203 concurrent with stall: pc_f = 0x200, ID is flushed (valid = 0, instr = NOP). The stall has no effect.
- Sequence through 0xFFFF_FFFC with redirect there: imem_addr shows 0xFFFF_FFFC then 0x0. pc4_id for pc_id 0xFFFF_FFFC is 0x0.
- Assert i_rst during an active stall with pc_f = 0x40: next cycle pc_f = RESET_PC, valid = 0, flush_cnt = 0. Then assert 70000 redirects: flush_cnt = 0xFFFF.

Source files
------------

// File: rtl/rv_if_stage.sv
// rv32i instruction-fetch stage: fetch PC, imem address and the IF/ID pipeline register.
// Redirects from EX flush IF/ID and take priority over the hazard-unit stall.
module rv_if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_stall,
  input  logic        i_if_redirect,
  input  logic [31:0] i_if_redirect_pc,
  output logic [31:0] o_if_imem_addr,
  input  logic [31:0] i_if_imem_rdata,
  output logic [31:0] o_if_pc_id,
  output logic [31:0] o_if_pc4_id,
  output logic [31:0] o_if_instr_id,
  output logic        o_if_valid_id,
  output logic [15:0] o_if_flush_cnt
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] pc_f_plus4;

  assign pc_f_plus4     = pc_f + XLEN'(4);
  assign o_if_imem_addr = pc_f;

  // Fetch PC: redirect > stall > sequential
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_f <= RESET_PC;
    end else if (i_if_redirect) begin
      pc_f <= {i_if_redirect_pc[XLEN-1:2], 2'b00};
    end else if (!i_if_stall) begin
      pc_f <= pc_f_plus4;
    end
  end

  // IF/ID register; a flush loads a bubble so imem data never reaches ID
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_if_pc_id    <= '0;
      o_if_pc4_id   <= '0;
      o_if_instr_id <= NOP_INSTR;
      o_if_valid_id <= 1'b0;
    end else if (i_if_redirect) begin
      o_if_pc_id    <= pc_f;
      o_if_pc4_id   <= pc_f_plus4;
      o_if_instr_id <= NOP_INSTR;
      o_if_valid_id <= 1'b0;
    end else if (!i_if_stall) begin
      o_if_pc_id    <= pc_f;
      o_if_pc4_id   <= pc_f_plus4;
      o_if_instr_id <= i_if_imem_rdata;
      o_if_valid_id <= 1'b1;
    end
  end

  // Saturating redirect-flush counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_if_flush_cnt <= '0;
    end else if (i_if_redirect && (o_if_flush_cnt != {CNT_W{1'b1}})) begin
      o_if_flush_cnt <= o_if_flush_cnt + CNT_W'(1);
    end
  end

endmodule
